// File: rtl/ram_arbiter.sv
// Two-port arbiter in front of a single-port RAM: fixed priority to A with a
// starvation guard for B, plus a clear sweep that writes CLEAR_VAL to every word.
module ram_arbiter #(
    parameter int              WIDTH     = 8,
    parameter int              DEPTH     = 3,
    parameter int              MAX_WAIT  = 4,
    parameter logic [WIDTH-1:0] CLEAR_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_req,
    input  logic             a_we,
    input  logic [DEPTH-1:0] a_addr,
    input  logic [WIDTH-1:0] a_wdata,
    output logic             a_gnt,
    output logic             a_rvalid,
    output logic [WIDTH-1:0] a_rdata,
    input  logic             b_req,
    input  logic             b_we,
    input  logic [DEPTH-1:0] b_addr,
    input  logic [WIDTH-1:0] b_wdata,
    output logic             b_gnt,
    output logic             b_rvalid,
    output logic [WIDTH-1:0] b_rdata,
    input  logic             clr_start,
    output logic             busy,
    output logic             ram_ena,
    output logic             ram_wena,
    output logic [DEPTH-1:0] ram_addr,
    output logic [WIDTH-1:0] ram_wdata,
    input  logic [WIDTH-1:0] ram_rdata
);

    typedef enum logic {ARB, CLEAR} state_t;

    state_t             state_q, state_d;
    logic [3:0]         wait_cnt_q, wait_cnt_d;
    logic [DEPTH-1:0]   clr_ptr_q, clr_ptr_d;
    logic               busy_q, busy_d;
    logic               a_rvalid_q, a_rvalid_d, b_rvalid_q, b_rvalid_d;
    logic [WIDTH-1:0]   a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
    logic               force_b, a_win, b_win;
    logic               ena_c, wena_c;
    logic [DEPTH-1:0]   addr_c;
    logic [WIDTH-1:0]   wdata_c;

    always_comb begin
        force_b = (wait_cnt_q == 4'(MAX_WAIT));
        a_win   = (state_q == ARB) && a_req && !force_b;
        b_win   = (state_q == ARB) && b_req && !a_win;

        ena_c   = 1'b0;
        wena_c  = 1'b0;
        addr_c  = '0;
        wdata_c = '0;
        if (state_q == CLEAR) begin
            ena_c   = 1'b1;
            wena_c  = 1'b1;
            addr_c  = clr_ptr_q;
            wdata_c = CLEAR_VAL;
        end else if (a_win) begin
            ena_c   = 1'b1;
            wena_c  = a_we;
            addr_c  = a_addr;
            wdata_c = a_wdata;
        end else if (b_win) begin
            ena_c   = 1'b1;
            wena_c  = b_we;
            addr_c  = b_addr;
            wdata_c = b_wdata;
        end
    end

    // Combinational outputs are forced quiet while reset is held.
    assign a_gnt     = rst_n & a_win;
    assign b_gnt     = rst_n & b_win;
    assign ram_ena   = rst_n & ena_c;
    assign ram_wena  = rst_n & wena_c;
    assign ram_addr  = rst_n ? addr_c  : '0;
    assign ram_wdata = rst_n ? wdata_c : '0;

    assign busy     = busy_q;
    assign a_rvalid = a_rvalid_q;
    assign a_rdata  = a_rdata_q;
    assign b_rvalid = b_rvalid_q;
    assign b_rdata  = b_rdata_q;

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        clr_ptr_d  = clr_ptr_q;
        busy_d     = busy_q;
        a_rvalid_d = a_win && !a_we;
        b_rvalid_d = b_win && !b_we;
        a_rdata_d  = a_rvalid_d ? ram_rdata : '0;
        b_rdata_d  = b_rvalid_d ? ram_rdata : '0;
        case (state_q)
            ARB: begin
                if (b_req && !b_win)
                    wait_cnt_d = force_b ? wait_cnt_q : wait_cnt_q + 4'd1;
                else
                    wait_cnt_d = '0;
                if (clr_start) begin
                    state_d   = CLEAR;
                    clr_ptr_d = '0;
                    busy_d    = 1'b1;
                end
            end
            CLEAR: begin
                clr_ptr_d = clr_ptr_q + 1'b1;
                if (clr_ptr_q == '1) begin
                    state_d = ARB;
                    busy_d  = 1'b0;
                end
            end
            default: state_d = ARB;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ARB;
            wait_cnt_q <= '0;
            clr_ptr_q  <= '0;
            busy_q     <= 1'b0;
            a_rvalid_q <= 1'b0;
            a_rdata_q  <= '0;
            b_rvalid_q <= 1'b0;
            b_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            clr_ptr_q  <= clr_ptr_d;
            busy_q     <= busy_d;
            a_rvalid_q <= a_rvalid_d;
            a_rdata_q  <= a_rdata_d;
            b_rvalid_q <= b_rvalid_d;
            b_rdata_q  <= b_rdata_d;
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a small behavioural RAM on the ram_* pins.
module tb_ram_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       a_req, a_we, b_req, b_we, clr_start;
    logic [2:0] a_addr, b_addr, ram_addr;
    logic [7:0] a_wdata, b_wdata, ram_wdata, ram_rdata, a_rdata, b_rdata;
    logic       a_gnt, b_gnt, a_rvalid, b_rvalid, busy, ram_ena, ram_wena;
    logic [7:0] mem [8];

    int chk_cnt  = 0;
    int pass_cnt = 0;

    ram_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .clr_start(clr_start), .busy(busy),
        .ram_ena(ram_ena), .ram_wena(ram_wena), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    assign ram_rdata = mem[ram_addr];
    always @(posedge clk) if (ram_ena && ram_wena) mem[ram_addr] <= ram_wdata;

    typedef struct {
        logic       ar, aw; logic [2:0] aa; logic [7:0] ad;
        logic       br, bw; logic [2:0] ba; logic [7:0] bd;
        logic       clr;
        logic       ag, bg, arv; logic [7:0] ard; logic brv; logic [7:0] brd;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic drv(input logic ar, input logic aw, input logic [2:0] aa, input logic [7:0] ad,
                       input logic br, input logic bw, input logic [2:0] ba, input logic [7:0] bd,
                       input logic clr);
        a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad;
        b_req = br; b_we = bw; b_addr = ba; b_wdata = bd;
        clr_start = clr;
    endtask

    task automatic idle();
        drv(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [7:0] val);
        for (int i = 0; i < 8; i++) begin
            drv(1'b1, 1'b1, 3'(i), val, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
            #3 chk("preload_gnt", {31'd0, a_gnt}, 32'd1);
            tick();
        end
        idle();
    endtask

    // Words below split are expected to hold lo, the rest hi.
    task automatic read_all(input logic [7:0] lo, input logic [7:0] hi, input int split);
        for (int i = 0; i <= 8; i++) begin
            if (i < 8) drv(1'b1, 1'b0, 3'(i), 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
            else idle();
            #3;
            if (i > 0) chk("readback", {23'd0, a_rvalid, a_rdata}, {23'd0, 1'b1, ((i - 1) < split) ? lo : hi});
            tick();
        end
    endtask

    // {busy, ram_ena, ram_wena, a_gnt, b_gnt, ram_addr, ram_wdata}
    task automatic chk_sweep(input int k);
        chk("sweep", {16'd0, busy, ram_ena, ram_wena, a_gnt, b_gnt, ram_addr, ram_wdata},
            {16'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'(k), 8'h00});
    endtask

    initial begin
        for (int i = 0; i < 8; i++) mem[i] = 8'h00;
        //           ar    aw    aa    ad     br    bw    ba    bd     clr   ag    bg    arv   ard    brv   brd
        vecs[0]  = '{1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00};
        vecs[1]  = '{1'b1, 1'b1, 3'd3, 8'h5A, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00};
        vecs[2]  = '{1'b1, 1'b0, 3'd3, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00};
        vecs[3]  = '{1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h5A, 1'b0, 8'h00};
        vecs[4]  = '{1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00};
        vecs[5]  = '{1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 1'b1, 3'd7, 8'hC3, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00};
        vecs[6]  = '{1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 3'd7, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00};
        vecs[7]  = '{1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'hC3};
        vecs[8]  = '{1'b1, 1'b0, 3'd3, 8'h00, 1'b1, 1'b1, 3'd1, 8'h77, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00};
        vecs[9]  = '{1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 3'd7, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'h5A, 1'b0, 8'h00};
        vecs[10] = '{1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'hC3};

        // Reset with a live request: everything must stay quiet.
        rst_n = 1'b0;
        drv(1'b1, 1'b1, 3'd5, 8'hAA, 1'b1, 1'b0, 3'd6, 8'h00, 1'b0);
        #3;
        chk("reset_out", {24'd0, a_gnt, b_gnt, ram_ena, ram_wena, busy, a_rvalid, b_rvalid, 1'b0}, 32'd0);
        chk("reset_data", {8'd0, a_rdata, b_rdata, ram_wdata}, 32'd0);
        chk("reset_addr", {29'd0, ram_addr}, 32'd0);
        idle();
        @(posedge clk); #1 rst_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            drv(vecs[i].ar, vecs[i].aw, vecs[i].aa, vecs[i].ad,
                vecs[i].br, vecs[i].bw, vecs[i].ba, vecs[i].bd, vecs[i].clr);
            #3;
            chk($sformatf("vec%0d", i),
                {12'd0, a_gnt, b_gnt, a_rvalid, a_rdata, b_rvalid, b_rdata},
                {12'd0, vecs[i].ag, vecs[i].bg, vecs[i].arv, vecs[i].ard, vecs[i].brv, vecs[i].brd});
            tick();
        end
        chk("b_write_ignored_when_a_wins", {24'd0, mem[1]}, 32'd0);

        // Continuous contention: B gets every 5th slot.
        for (int c = 0; c < 10; c++) begin
            drv(1'b1, 1'b0, 3'd3, 8'h00, 1'b1, 1'b0, 3'd7, 8'h00, 1'b0);
            #3 chk($sformatf("starve%0d", c), {30'd0, a_gnt, b_gnt}, (c % 5 == 4) ? 32'd1 : 32'd2);
            tick();
        end
        idle();

        // Clear sweep, started in the same cycle as an A write to addr 2.
        preload(8'hFF);
        drv(1'b1, 1'b1, 3'd2, 8'h11, 1'b0, 1'b0, 3'd0, 8'h00, 1'b1);
        #3 chk("clr_cycle_gnt", {30'd0, a_gnt, busy}, 32'd2);
        tick();
        drv(1'b1, 1'b0, 3'd5, 8'h00, 1'b1, 1'b0, 3'd6, 8'h00, 1'b1);
        #3 chk("pre_sweep_write", {24'd0, mem[2]}, 32'h11);
        for (int k = 0; k < 8; k++) begin
            if (k > 0) #3;
            chk_sweep(k);
            tick();
            clr_start = 1'b0;
        end
        #3 chk("sweep_done", {30'd0, busy, a_gnt}, 32'd1);
        idle();
        tick();
        read_all(8'h00, 8'h00, 8);

        // Reset in the middle of a sweep; wait_cnt is non-zero going in.
        preload(8'hFF);
        for (int c = 0; c < 2; c++) begin
            drv(1'b1, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 3'd1, 8'h00, 1'b0);
            #3 chk("pre_clr_contend", {30'd0, a_gnt, b_gnt}, 32'd2);
            tick();
        end
        drv(1'b1, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 3'd1, 8'h00, 1'b1);
        #3 chk("clr2_cycle_gnt", {30'd0, a_gnt, b_gnt}, 32'd2);
        tick();
        clr_start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #3 chk_sweep(k);
            tick();
        end
        #3 chk_sweep(4);
        #2 rst_n = 1'b0;
        #1 chk("mid_sweep_reset", {26'd0, busy, ram_ena, ram_wena, a_gnt, b_gnt, a_rvalid}, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #3 chk($sformatf("post_reset_starve%0d", c), {30'd0, a_gnt, b_gnt}, (c == 4) ? 32'd1 : 32'd2);
            tick();
        end
        idle();
        tick();
        read_all(8'h00, 8'hFF, 4);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares one single-port `ram` instance between two requesters: port A (data-memory stage, high priority) and port B (secondary master, e.g. debug/loader).
- Fixed priority to A, plus an anti-starvation counter that forces one B grant after B has waited MAX_WAIT consecutive cycles.
- Contains a clear sequencer that, on command, writes CLEAR_VAL to every RAM word and blocks both requesters while it runs.
- Sits between the pipeline's MEM stage and the RAM's ram_ena/wena/addr/data_in/data_out pins. RAM read is combinational; write takes effect at the clock edge.

Parameters:
- WIDTH, 8, RAM data width.
- DEPTH, 3, RAM address bits (2**DEPTH words).
- MAX_WAIT, 4, consecutive denied-B cycles before B is forced ahead of A; range 1..15.
- CLEAR_VAL, 0, word written during clear sweep.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- a_req  input  1  port A access request.
- a_we  input  1  port A write enable (1 = write, 0 = read).
- a_addr  input  DEPTH  port A address.
- a_wdata  input  WIDTH  port A write data.
- a_gnt  output  1  port A accepted this cycle (combinational).
- a_rvalid  output  1  port A read data valid (registered).
- a_rdata  output  WIDTH  port A read data (registered).
- b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata: same as port A, for port B.
- clr_start  input  1  one-cycle pulse to start clear sweep.
- busy  output  1  high while clear sweep runs.
- ram_ena  output  1  to RAM ram_ena.
- ram_wena  output  1  to RAM wena.
- ram_addr  output  DEPTH  to RAM addr.
- ram_wdata  output  WIDTH  to RAM data_in.
- ram_rdata  input  WIDTH  from RAM data_out (combinational).

Behaviour:
- Reset (async, rst_n=0):
  - state=ARB, wait_cnt=0, clr_ptr=0.
  - busy=0, a_rvalid=b_rvalid=0, a_rdata=b_rdata=0.
  - All ram_* outputs and grants are 0 while reset is asserted.
- FSM states: ARB, CLEAR.
- ARB:
  - Winner: A if a_req and not force_b; else B if b_req. force_b = (wait_cnt == MAX_WAIT).
  - A grant is a single cycle:
    - gnt of the winner = 1, combinational in the same cycle.
    - ram_ena=1; ram_wena/addr/wdata are muxed from the winner.
    - The other requester's signals are ignored.
  - No request: ram_ena=0, ram_wena=0, ram_addr=0, ram_wdata=0.
  - Read grant: at the next edge, the winner's rdata <= ram_rdata and its rvalid <= 1 for exactly one cycle. Both are cleared the following cycle unless another read grant occurs.
  - Write grant: rvalid stays 0; RAM word updated at that edge.
  - A requester holding req high is re-arbitrated every cycle. Back-to-back grants give throughput of one access per cycle.
- wait_cnt (4 bits):
  - Increments when b_req=1 and b_gnt=0; saturates at MAX_WAIT.
  - Clears when b_gnt=1 or b_req=0.
  - Not modified in CLEAR.
- ARB→CLEAR on clr_start=1 in ARB:
  - That cycle's arbitration still completes normally.
  - Next cycle: busy=1, clr_ptr=0.
- CLEAR:
  - Each cycle: ram_ena=1, ram_wena=1, ram_addr=clr_ptr, ram_wdata=CLEAR_VAL. clr_ptr increments.
  - a_gnt=b_gnt=0 regardless of req.
  - After writing address 2**DEPTH-1, return to ARB next cycle, busy=0, clr_ptr wraps to 0.
  - Sweep length is exactly 2**DEPTH cycles.
  - clr_start during CLEAR is ignored (no restart).
- Reset mid-sweep: immediately returns to ARB with busy=0. Partially cleared RAM contents are left as-is.
- Simultaneous a_req and b_req with force_b=0: A wins and wait_cnt increments.
- Address and data pass through unmodified; no width conversion.

Test Plan:
- Reset, then a_req write addr=3 data=0x5A, then a_req read addr=3 -> a_gnt=1 both cycles; next cycle after read, a_rvalid=1, a_rdata=0x5A; b_* idle.
- a_req and b_req held high continuously, MAX_WAIT=4 -> b_gnt=0 for 4 cycles, b_gnt=1 on the 5th, then A again; pattern repeats every 5 cycles.
- b_req read addr=7 with a_req low -> b_gnt=1 the same cycle; b_rvalid=1, b_rdata=RAM[7] one cycle later; a_rvalid stays 0.
- Preload all words 0xFF, pulse clr_start with DEPTH=3 -> busy=1 for exactly 8 cycles; ram_addr steps 0..7 with wena=1; grants 0 despite requests; all words then read 0x00.
- Assert rst_n=0 at sweep address 4 -> busy=0 asynchronously; after release, words 0..3 read 0x00, 4..7 read 0xFF; arbitration resumes with wait_cnt=0.
- clr_start pulsed in the same cycle as an a_req write to addr=2, data=0x11 -> write is granted; the sweep then starts and clears addr 2 to 0x00.
